// File: rtl/image_stream_rx_ctrl.sv
// image_stream_rx_ctrl
// Receives a raw pixel byte stream from the UART RX path and writes it into a
// double-buffered frame store through a req/ready memory port. The host is
// acknowledged every ACK_CHUNK bytes, and the active bank flips when a frame
// completes.
//
// Optional feature macro: IMAGE_STREAM_TIMEOUT_EN
//   When defined, a gap counter aborts a stalled frame with a NAK and a
//   frame_error pulse. When undefined, frame_error is tied low and WAIT_RX
//   waits indefinitely.
//
// Bank usage: the write bank is always the complement of active_bank, so the
// display never reads a bank that is being written. After reset
// active_bank=0, which means the first frame lands in bank 1.

module image_stream_rx_ctrl #(
  parameter int          IMAGE_BUF_X     = 4,
  parameter int          IMAGE_BUF_Y     = 3,
  parameter int          BYTES_PER_PIXEL = 2,
  parameter int          ACK_CHUNK       = 1,
  parameter logic [7:0]  START_BYTE      = 8'h06,
  parameter logic [7:0]  ACK_BYTE        = 8'h06,
  parameter logic [7:0]  NAK_BYTE        = 8'h15,
  parameter int          TIMEOUT_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        tx_busy,
  input  logic        mem_ready,
  output logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_in,
  output logic        streaming_ended,
  output logic        active_bank,
  output logic        frame_error
);

  localparam int FRAME_BYTES = IMAGE_BUF_X * IMAGE_BUF_Y * BYTES_PER_PIXEL;
  localparam int IDX_W       = $clog2(FRAME_BYTES + 1);
  localparam int CNT_W       = $clog2(ACK_CHUNK + 1);

  localparam logic [IDX_W-1:0] FRAME_END      = IDX_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] CHUNK_END      = CNT_W'(ACK_CHUNK);
  localparam logic [31:0]      FRAME_BYTES_32 = 32'(FRAME_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RX,
    MEM_WR,
    ACK_WAIT,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] chunk_reg, chunk_next;
  logic             last_reg, last_next;
  logic             active_bank_reg, active_bank_next;
  logic             mem_req_reg, mem_req_next;
  logic [31:0]      mem_addr_reg, mem_addr_next;
  logic [7:0]       mem_in_reg, mem_in_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic             tx_ready_reg, tx_ready_next;
  logic             ended_reg, ended_next;

  logic [IDX_W-1:0] idx_inc;
  logic [CNT_W-1:0] chunk_inc;

`ifdef IMAGE_STREAM_TIMEOUT_EN
  localparam logic [31:0] GAP_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] gap_reg, gap_next;
  logic        nak_reg, nak_next;
  logic        error_reg, error_next;
`endif

  assign idx_inc   = idx_reg + IDX_W'(1);
  assign chunk_inc = chunk_reg + CNT_W'(1);

  // State and registered outputs; reset drops any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      chunk_reg       <= '0;
      last_reg        <= 1'b0;
      active_bank_reg <= 1'b0;
      mem_req_reg     <= 1'b0;
      mem_addr_reg    <= '0;
      mem_in_reg      <= '0;
      tx_data_reg     <= '0;
      tx_ready_reg    <= 1'b0;
      ended_reg       <= 1'b0;
`ifdef IMAGE_STREAM_TIMEOUT_EN
      gap_reg         <= '0;
      nak_reg         <= 1'b0;
      error_reg       <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      chunk_reg       <= chunk_next;
      last_reg        <= last_next;
      active_bank_reg <= active_bank_next;
      mem_req_reg     <= mem_req_next;
      mem_addr_reg    <= mem_addr_next;
      mem_in_reg      <= mem_in_next;
      tx_data_reg     <= tx_data_next;
      tx_ready_reg    <= tx_ready_next;
      ended_reg       <= ended_next;
`ifdef IMAGE_STREAM_TIMEOUT_EN
      gap_reg         <= gap_next;
      nak_reg         <= nak_next;
      error_reg       <= error_next;
`endif
    end
  end

  // Next-state and output decode; strobes default low, everything else holds.
  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    chunk_next       = chunk_reg;
    last_next        = last_reg;
    active_bank_next = active_bank_reg;
    mem_req_next     = mem_req_reg;
    mem_addr_next    = mem_addr_reg;
    mem_in_next      = mem_in_reg;
    tx_data_next     = tx_data_reg;
    tx_ready_next    = 1'b0;
    ended_next       = 1'b0;
`ifdef IMAGE_STREAM_TIMEOUT_EN
    gap_next         = gap_reg;
    nak_next         = nak_reg;
    error_next       = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        // Only the start code opens a frame; anything else is noise.
        if (rx_ready && (rx_data == START_BYTE)) begin
          state_next = WAIT_RX;
          idx_next   = '0;
          chunk_next = '0;
          last_next  = 1'b0;
`ifdef IMAGE_STREAM_TIMEOUT_EN
          gap_next   = '0;
`endif
        end
      end

      WAIT_RX: begin
        if (rx_ready) begin
          // Address is captured once here so it stays stable for the whole
          // memory handshake.
          mem_in_next   = rx_data;
          mem_addr_next = (active_bank_reg ? 32'd0 : FRAME_BYTES_32)
                          + 32'(idx_reg);
          mem_req_next  = 1'b1;
          state_next    = MEM_WR;
`ifdef IMAGE_STREAM_TIMEOUT_EN
          gap_next      = '0;
`endif
        end
`ifdef IMAGE_STREAM_TIMEOUT_EN
        else if (gap_reg == GAP_LIMIT) begin
          nak_next   = 1'b1;
          gap_next   = '0;
          state_next = ACK_WAIT;
        end else begin
          gap_next = gap_reg + 32'd1;
        end
`endif
      end

      MEM_WR: begin
        // mem_req is always high in this state, so a stray mem_ready
        // elsewhere never advances anything.
        if (mem_ready) begin
          mem_req_next = 1'b0;
          idx_next     = idx_inc;
          chunk_next   = chunk_inc;
          last_next    = (idx_inc == FRAME_END);
          if ((idx_inc == FRAME_END) || (chunk_inc == CHUNK_END)) begin
            state_next = ACK_WAIT;
          end else begin
            state_next = WAIT_RX;
          end
        end
      end

      ACK_WAIT: begin
        if (!tx_busy) begin
          tx_ready_next = 1'b1;
          chunk_next    = '0;
`ifdef IMAGE_STREAM_TIMEOUT_EN
          if (nak_reg) begin
            // Aborted frame: the partial bank is abandoned, display bank kept.
            tx_data_next = NAK_BYTE;
            error_next   = 1'b1;
            nak_next     = 1'b0;
            last_next    = 1'b0;
            idx_next     = '0;
            state_next   = IDLE;
          end else begin
            tx_data_next = ACK_BYTE;
            gap_next     = '0;
            state_next   = last_reg ? DONE : WAIT_RX;
          end
`else
          tx_data_next = ACK_BYTE;
          state_next   = last_reg ? DONE : WAIT_RX;
`endif
        end
      end

      DONE: begin
        ended_next       = 1'b1;
        active_bank_next = ~active_bank_reg;
        last_next        = 1'b0;
        idx_next         = '0;
        state_next       = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tx_data         = tx_data_reg;
  assign tx_ready        = tx_ready_reg;
  assign mem_req         = mem_req_reg;
  assign mem_addr        = mem_addr_reg;
  assign mem_in          = mem_in_reg;
  assign streaming_ended = ended_reg;
  assign active_bank     = active_bank_reg;

`ifdef IMAGE_STREAM_TIMEOUT_EN
  assign frame_error = error_reg;
`else
  // Timeout-only configuration has no effect in this build.
  logic unused_cfg;
  assign unused_cfg  = ^{NAK_BYTE, TIMEOUT_CYCLES};
  assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_image_stream_rx_ctrl.sv
// Bench for image_stream_rx_ctrl: two instances (ACK_CHUNK=1 and ACK_CHUNK=5)
// share one stimulus stream. A transaction-level model turns every byte sent
// into the ordered list of memory writes, ACK bytes and frame-end pulses each
// instance must produce; a per-cycle compare process pops that list.

module tb_image_stream_rx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_busy;
  logic        mem_ready;

  logic [7:0]  tx_data_w  [2];
  logic        tx_ready_w [2];
  logic        mem_req_w  [2];
  logic [31:0] mem_addr_w [2];
  logic [7:0]  mem_in_w   [2];
  logic        ended_w    [2];
  logic        bank_w     [2];
  logic        ferr_w     [2];

  image_stream_rx_ctrl dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_busy(tx_busy), .mem_ready(mem_ready),
    .tx_data(tx_data_w[0]), .tx_ready(tx_ready_w[0]), .mem_req(mem_req_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_in(mem_in_w[0]),
    .streaming_ended(ended_w[0]), .active_bank(bank_w[0]),
    .frame_error(ferr_w[0])
  );

  image_stream_rx_ctrl #(.ACK_CHUNK(5)) dut5 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_busy(tx_busy), .mem_ready(mem_ready),
    .tx_data(tx_data_w[1]), .tx_ready(tx_ready_w[1]), .mem_req(mem_req_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_in(mem_in_w[1]),
    .streaming_ended(ended_w[1]), .active_bank(bank_w[1]),
    .frame_error(ferr_w[1])
  );

  localparam int         FB    = 24;
  localparam logic [7:0] START = 8'h06;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [1:0] EV_W  = 2'd0;
  localparam logic [1:0] EV_A  = 2'd1;
  localparam logic [1:0] EV_E  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  int checks   = 0;
  int failures = 0;

  int m_in [2];
  int m_idx [2];
  int m_cnt [2];
  int m_bank [2];
  int exp_bank [2];
  int wr_cnt [2];
  int ack_cnt [2];
  int end_cnt [2];
  logic [31:0] addr_log[$];
  int ackpos[$];
  logic busy_prev = 1'b0;

  function automatic int chunk_of(int d);
    return (d == 0) ? 1 : 5;
  endfunction

  task automatic push_ev(int d, ev_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qfront(int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Spec-level model: what one received byte obliges the controller to emit.
  task automatic model_accept(int d, logic [7:0] b);
    ev_t e;
    if (m_in[d] == 0) begin
      if (b == START) begin
        m_in[d]  = 1;
        m_idx[d] = 0;
        m_cnt[d] = 0;
      end
      return;
    end
    e.kind = EV_W;
    e.addr = 32'(((m_bank[d] != 0) ? 0 : FB) + m_idx[d]);
    e.data = b;
    push_ev(d, e);
    m_idx[d]++;
    m_cnt[d]++;
    if (m_cnt[d] == chunk_of(d) || m_idx[d] == FB) begin
      e.kind = EV_A; e.addr = 32'd0; e.data = ACK;
      push_ev(d, e);
      m_cnt[d] = 0;
    end
    if (m_idx[d] == FB) begin
      e.kind = EV_E; e.addr = 32'd0; e.data = 8'd0;
      push_ev(d, e);
      m_in[d]   = 0;
      m_bank[d] = m_bank[d] ^ 1;
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      m_in[d] = 0; m_idx[d] = 0; m_cnt[d] = 0; m_bank[d] = 0; exp_bank[d] = 0;
    end
  endtask

  // Compare one instance's outputs against the head of its expected list.
  task automatic observe(int d);
    ev_t   f;
    string tag;
    tag = (d == 0) ? "c1" : "c5";
    if (mem_req_w[d]) begin
      if (qsize(d) == 0) begin
        checks++; failures++;
        $display("FAIL %s_unexpected_mem_req addr=%0h required=no request", tag, mem_addr_w[d]);
      end else begin
        f = qfront(d);
        if (f.kind != EV_W) begin
          checks++; failures++;
          $display("FAIL %s_unexpected_mem_req addr=%0h required=event kind %0d", tag, mem_addr_w[d], f.kind);
        end else begin
          check($sformatf("%s_mem_addr", tag), mem_addr_w[d], f.addr);
          check($sformatf("%s_mem_in", tag), 32'(mem_in_w[d]), 32'(f.data));
          if (mem_ready) begin
            qpop(d);
            wr_cnt[d]++;
            if (d == 0) addr_log.push_back(mem_addr_w[d]);
            $display("c%0d write addr=%0d data=%02h", chunk_of(d), mem_addr_w[d], mem_in_w[d]);
          end
        end
      end
    end
    if (tx_ready_w[d]) begin
      check($sformatf("%s_tx_while_busy", tag), 32'(busy_prev), 32'd0);
      if (qsize(d) == 0) begin
        checks++; failures++;
        $display("FAIL %s_unexpected_tx data=%02h required=no strobe", tag, tx_data_w[d]);
      end else begin
        f = qfront(d);
        if (f.kind != EV_A) begin
          checks++; failures++;
          $display("FAIL %s_unexpected_tx data=%02h required=event kind %0d", tag, tx_data_w[d], f.kind);
        end else begin
          check($sformatf("%s_tx_data", tag), 32'(tx_data_w[d]), 32'(f.data));
          qpop(d);
          ack_cnt[d]++;
          if (d == 1) ackpos.push_back(wr_cnt[1]);
          $display("c%0d ack data=%02h after_writes=%0d", chunk_of(d), tx_data_w[d], wr_cnt[d]);
        end
      end
    end
    if (ended_w[d]) begin
      if (qsize(d) == 0) begin
        checks++; failures++;
        $display("FAIL %s_unexpected_end actual=1 required=0", tag);
      end else begin
        f = qfront(d);
        if (f.kind != EV_E) begin
          checks++; failures++;
          $display("FAIL %s_unexpected_end actual=1 required=event kind %0d", tag, f.kind);
        end else begin
          qpop(d);
          exp_bank[d] = exp_bank[d] ^ 1;
          end_cnt[d]++;
          $display("c%0d frame end active_bank=%0d", chunk_of(d), bank_w[d]);
        end
      end
    end
    check($sformatf("%s_active_bank", tag), 32'(bank_w[d]), 32'(exp_bank[d]));
    check($sformatf("%s_frame_error", tag), 32'(ferr_w[d]), 32'd0);
  endtask

  always @(posedge clk) busy_prev <= tx_busy;

  always @(negedge clk) begin
    if (!reset) begin
      observe(0);
      observe(1);
    end
  end

  task automatic drain(string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_drain_timeout pending=%0d/%0d required=0/0", name, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_ready = 1'b1;
    model_accept(0, b);
    model_accept(1, b);
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    reset    = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_zero(string name);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_c%0d_outs", name, chunk_of(d)),
            {tx_data_w[d], mem_in_w[d], 5'd0, tx_ready_w[d], mem_req_w[d], ended_w[d]},
            32'd0);
      check($sformatf("%s_c%0d_addr", name, chunk_of(d)), mem_addr_w[d], 32'd0);
      check($sformatf("%s_c%0d_bank", name, chunk_of(d)), 32'(bank_w[d]), 32'd0);
    end
  endtask

  initial begin
    int base_ack0, base_ack1, base_wr0;
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_ready  = 1'b0;
    tx_busy   = 1'b0;
    mem_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      wr_cnt[d] = 0; ack_cnt[d] = 0; end_cnt[d] = 0;
    end
    model_reset();
    do_reset();
    check_zero("reset");

    // Frame 1: active_bank=0, so it is written into bank 1 (addresses 24..47).
    addr_log.delete(); ackpos.delete();
    send(START); drain("f1_start");
    for (int i = 0; i < FB; i++) begin send(8'(i)); drain("f1"); end
    check("f1_acks_c1", ack_cnt[0], 24);
    check("f1_acks_c5", ack_cnt[1], 5);
    check("f1_ends_c1", end_cnt[0], 1);
    check("f1_ends_c5", end_cnt[1], 1);
    check("f1_bank_c1", 32'(bank_w[0]), 1);
    check("f1_bank_c5", 32'(bank_w[1]), 1);
    check("f1_writes", addr_log.size(), 24);
    check("f1_first_addr", addr_log[0], 24);
    check("f1_last_addr", addr_log[23], 47);
    check("f1_ackpos_n", ackpos.size(), 5);
    check("f1_ackpos0", ackpos[0], 5);
    check("f1_ackpos1", ackpos[1], 10);
    check("f1_ackpos2", ackpos[2], 15);
    check("f1_ackpos3", ackpos[3], 20);
    check("f1_ackpos4", ackpos[4], 24);

    // Frame 2: back into bank 0, active_bank returns to 0.
    addr_log.delete();
    send(START); drain("f2_start");
    for (int i = 0; i < FB; i++) begin send(8'(255 - i)); drain("f2"); end
    check("f2_first_addr", addr_log[0], 0);
    check("f2_last_addr", addr_log[23], 23);
    check("f2_bank_c1", 32'(bank_w[0]), 0);
    check("f2_ends_c1", end_cnt[0], 2);

    // Idle noise is dropped, then a START opens frame 3.
    base_wr0 = wr_cnt[0];
    send(8'h41); send(8'h00);
    repeat (10) @(posedge clk);
    #1;
    check("idle_noise_writes", wr_cnt[0], base_wr0);
    check("idle_noise_req", 32'(mem_req_w[0]), 0);
    addr_log.delete();
    send(START); drain("f3_start");

    // TX busy for 50 cycles at the first ACK.
    base_ack0 = ack_cnt[0];
    base_ack1 = ack_cnt[1];
    tx_busy = 1'b1;
    send(8'h11);
    repeat (50) @(posedge clk);
    #1;
    check("busy_no_ack", ack_cnt[0], base_ack0);
    tx_busy = 1'b0;
    drain("f3_busy");
    check("busy_ack_after", ack_cnt[0], base_ack0 + 1);
    check("f3_first_addr", addr_log[0], 24);

    // Memory stall for 10 cycles on the second byte.
    base_wr0 = wr_cnt[0];
    mem_ready = 1'b0;
    send(8'h22);
    repeat (10) @(posedge clk);
    #1;
    check("stall_req_held", 32'(mem_req_w[0]), 1);
    check("stall_addr_held", mem_addr_w[0], 25);
    check("stall_no_write", wr_cnt[0], base_wr0);
    mem_ready = 1'b1;
    drain("f3_stall");
    for (int i = 2; i < FB; i++) begin send(8'(8'h30 + i)); drain("f3"); end
    check("f3_ends_c1", end_cnt[0], 3);
    check("f3_bank_c1", 32'(bank_w[0]), 1);
    check("f3_ack_delta_c5", ack_cnt[1] - base_ack1, 5);

    // Frame 4 aborted by reset after 7 bytes.
    send(START); drain("f4_start");
    for (int i = 0; i < 7; i++) begin send(8'(8'hC0 + i)); drain("f4"); end
    base_ack0 = ack_cnt[0];
    do_reset();
    check_zero("midreset");
    repeat (5) @(posedge clk);
    #1;
    check("midreset_no_ack", ack_cnt[0], base_ack0);

    // Fresh frame after reset starts at index 0 of bank 1 again.
    addr_log.delete();
    send(START); drain("f5_start");
    for (int i = 0; i < FB; i++) begin send(8'(i * 3)); drain("f5"); end
    check("f5_first_addr", addr_log[0], 24);
    check("f5_writes", addr_log.size(), 24);
    check("f5_bank_c1", 32'(bank_w[0]), 1);
    check("f5_bank_c5", 32'(bank_w[1]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
